control_fsm: RTL and testbench
==============================

# control_fsm

Multi-cycle instruction sequencer for the 16-bit core. Consumes the instruction word returned by the program management system and drives every strobe that system takes: PC/RA writes, memory reads and writes, source selects, and restore. It also drives the register-file write-back controls. Each instruction walks FETCH → DECODE → optional IMM/MEM/EXEC/WB, and PC advances only on the instruction's last cycle.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  fetch enable; sampled only in FETCH
- IR  in  16  instruction word; opcode = IR[15:12]
- writePC, writeRA, PCsrc, ImRPC, restore  out  1 each  PC-side controls
- Memsrc, MemR1, MemR2, MemW1, MemW2  out  1 each  memory controls
- conditionalBop  out  1  PC write gated by the branch condition inside the PC subsystem
- regWrite, aluSrc, memToReg  out  1 each  write-back controls
- halted  out  1  high once HALT has executed
- illegal  out  1  one-cycle pulse on an undefined opcode
- instrCount  out  16  retired-instruction counter

## Operation
- States: FETCH, DECODE, IMM, MEM, EXEC, WB, HALT.
- Strobes are decoded from the current state and IR[15:12]. Any strobe not listed in a state is 0.
- MemW1 is tied 0 (port 1 is read-only).
- FETCH:
  - run=1: MemR1=1, next state DECODE.
  - run=0: all outputs 0, stay in FETCH.
- DECODE (IR is valid here), by opcode:
  - 0x0 NOP, and undefined 0x9–0xE: writePC=1; next FETCH. Undefined opcodes also pulse illegal.
  - 0x1 ALU reg: next WB.
  - 0x2 ALU imm, 0x5 BRANCH, 0x6 JUMP, 0x7 CALL: next IMM.
  - 0x3 LOAD, 0x4 STORE: next MEM.
  - 0x8 RET: restore=1, writePC=1; next FETCH.
  - 0xF HALT: next HALT. No PC write.
- IMM: MemR2=1, Memsrc=0 (fetches the second word into ImR). Next: 0x2 → WB, otherwise EXEC.
- MEM: Memsrc=1.
  - LOAD: MemR2=1; next WB.
  - STORE: MemW2=1, writePC=1; next FETCH.
- EXEC: writePC=1, PCsrc=1, ImRPC=1.
  - BRANCH: conditionalBop=1.
  - CALL: writeRA=1.
  - All: next FETCH.
- WB: regWrite=1, writePC=1; next FETCH.
  - ALU imm: aluSrc=1, ImRPC=1.
  - LOAD: memToReg=1.
- HALT: all strobes 0, halted=1. Only reset leaves this state.
- PC increment rule: PCsrc=0 with ImRPC=0 gives PC+1; with ImRPC=1 gives PC+2.
- instrCount increments by 1 on every cycle that asserts writePC, and on the DECODE cycle of HALT. It wraps 0xFFFF → 0x0000.

## Timing
- Reset (async assert, sync release): state=FETCH, instrCount=0, halted=0. While reset_n=0, every output is forced 0.
- Cycles per instruction:
  - NOP, RET, illegal: 2.
  - ALU reg, STORE: 3.
  - ALU imm, LOAD, BRANCH, JUMP, CALL: 4.
- First FETCH strobe appears in the first cycle after reset_n rises, provided run=1.
- run is ignored outside FETCH. Dropping it mid-instruction completes that instruction, then holds in FETCH.
- IR must stay stable from the cycle after FETCH through the instruction's last cycle. MemR2 never alters IR.
- At most one of MemR1, MemR2, MemW2 is asserted in any cycle.
- Reset asserted mid-instruction: the instruction is abandoned with no partial PC write. The sequencer restarts at FETCH.

## Test plan
- Reset, run=1, IR=0x0000 held: FETCH/DECODE alternate. writePC pulses every 2nd cycle and instrCount reaches 5 after 10 cycles.
- IR=0x7xxx (CALL): MemR1, then no strobes, then MemR2+Memsrc=0, then writePC+PCsrc+ImRPC+writeRA together on cycle 4; instrCount+1.
- IR=0x3xxx (LOAD), then IR=0x4xxx (STORE): LOAD gives MEM cycle MemR2=1/Memsrc=1, then WB regWrite=1/memToReg=1/writePC=1. STORE gives MemW2=1 and writePC=1 in the same cycle, 3 cycles total.
- IR=0xAxxx: illegal pulses exactly once in DECODE with writePC=1. Then IR=0xFxxx: halted=1 and all strobes stay 0 for 20 cycles. Asserting reset_n=0 clears halted asynchronously.
- Preload instrCount to 0xFFFF via a NOP stream: the next retire yields 0x0000. Deassert run in WB of an ALU op: the instruction retires, then FETCH holds with MemR1=0.

Source files
------------

// File: rtl/control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : control_fsm                                                   |
// | Purpose  : Multi-cycle instruction sequencer for the 16-bit core. Walks  |
// |            FETCH -> DECODE -> optional IMM/MEM/EXEC/WB per instruction   |
// |            and drives the PC, memory and write-back strobes.             |
// | Ports    : clk, reset_n (async, active-low), run (fetch enable),         |
// |            IR[15:0] (opcode in IR[15:12])                                |
// |            PC side : writePC, writeRA, PCsrc, ImRPC, restore,            |
// |                      conditionalBop                                      |
// |            Memory  : Memsrc, MemR1, MemR2, MemW1 (tied 0), MemW2         |
// |            WB      : regWrite, aluSrc, memToReg                          |
// |            Status  : halted, illegal (1-cycle pulse), instrCount[15:0]   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module control_fsm (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [15:0] IR,
    output logic        writePC,
    output logic        writeRA,
    output logic        PCsrc,
    output logic        ImRPC,
    output logic        restore,
    output logic        Memsrc,
    output logic        MemR1,
    output logic        MemR2,
    output logic        MemW1,
    output logic        MemW2,
    output logic        conditionalBop,
    output logic        regWrite,
    output logic        aluSrc,
    output logic        memToReg,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instrCount
);

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_IMM    = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_EXEC   = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;
    localparam logic [2:0] c_ST_HALT   = 3'd6;

    localparam logic [3:0] c_OP_NOP    = 4'h0;
    localparam logic [3:0] c_OP_ALUR   = 4'h1;
    localparam logic [3:0] c_OP_ALUI   = 4'h2;
    localparam logic [3:0] c_OP_LOAD   = 4'h3;
    localparam logic [3:0] c_OP_STORE  = 4'h4;
    localparam logic [3:0] c_OP_BRANCH = 4'h5;
    localparam logic [3:0] c_OP_JUMP   = 4'h6;
    localparam logic [3:0] c_OP_CALL   = 4'h7;
    localparam logic [3:0] c_OP_RET    = 4'h8;
    localparam logic [3:0] c_OP_HALT   = 4'hF;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [3:0]  w_opcode;
    logic [15:0] r_instr_count;

    logic w_write_pc, w_write_ra, w_pc_src, w_imr_pc, w_restore;
    logic w_mem_src, w_mem_r1, w_mem_r2, w_mem_w2, w_cond_bop;
    logic w_reg_write, w_alu_src, w_mem_to_reg, w_halted, w_illegal;
    logic w_count_en;

    assign w_opcode = IR[15:12];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_write_pc   = 1'b0;
        w_write_ra   = 1'b0;
        w_pc_src     = 1'b0;
        w_imr_pc     = 1'b0;
        w_restore    = 1'b0;
        w_mem_src    = 1'b0;
        w_mem_r1     = 1'b0;
        w_mem_r2     = 1'b0;
        w_mem_w2     = 1'b0;
        w_cond_bop   = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_halted     = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                if (run) begin
                    w_mem_r1     = 1'b1;
                    w_next_state = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                case (w_opcode)
                    c_OP_NOP: begin
                        w_write_pc   = 1'b1;
                        w_next_state = c_ST_FETCH;
                    end
                    c_OP_ALUR:   w_next_state = c_ST_WB;
                    c_OP_ALUI,
                    c_OP_BRANCH,
                    c_OP_JUMP,
                    c_OP_CALL:   w_next_state = c_ST_IMM;
                    c_OP_LOAD,
                    c_OP_STORE:  w_next_state = c_ST_MEM;
                    c_OP_RET: begin
                        w_restore    = 1'b1;
                        w_write_pc   = 1'b1;
                        w_next_state = c_ST_FETCH;
                    end
                    c_OP_HALT:   w_next_state = c_ST_HALT;
                    default: begin
                        // 0x9..0xE: retire as a NOP and flag it
                        w_write_pc   = 1'b1;
                        w_illegal    = 1'b1;
                        w_next_state = c_ST_FETCH;
                    end
                endcase
            end
            c_ST_IMM: begin
                // Second instruction word goes into ImR via read port 2
                w_mem_r2     = 1'b1;
                w_next_state = (w_opcode == c_OP_ALUI) ? c_ST_WB : c_ST_EXEC;
            end
            c_ST_MEM: begin
                w_mem_src = 1'b1;
                if (w_opcode == c_OP_LOAD) begin
                    w_mem_r2     = 1'b1;
                    w_next_state = c_ST_WB;
                end else begin
                    w_mem_w2     = 1'b1;
                    w_write_pc   = 1'b1;
                    w_next_state = c_ST_FETCH;
                end
            end
            c_ST_EXEC: begin
                w_write_pc   = 1'b1;
                w_pc_src     = 1'b1;
                w_imr_pc     = 1'b1;
                w_cond_bop   = (w_opcode == c_OP_BRANCH);
                w_write_ra   = (w_opcode == c_OP_CALL);
                w_next_state = c_ST_FETCH;
            end
            c_ST_WB: begin
                w_reg_write  = 1'b1;
                w_write_pc   = 1'b1;
                // ALU-imm skips the immediate word: PC+2
                w_alu_src    = (w_opcode == c_OP_ALUI);
                w_imr_pc     = (w_opcode == c_OP_ALUI);
                w_mem_to_reg = (w_opcode == c_OP_LOAD);
                w_next_state = c_ST_FETCH;
            end
            c_ST_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_next_state = c_ST_FETCH;
            end
        endcase
    end

    // HALT retires in DECODE even though it never writes the PC
    assign w_count_en = w_write_pc ||
                        ((r_state == c_ST_DECODE) && (w_opcode == c_OP_HALT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr_count <= 16'h0000;
        end else if (w_count_en) begin
            r_instr_count <= r_instr_count + 16'h0001;
        end
    end

    // Outputs are decoded from state plus live inputs, so they are masked
    // while reset is held to keep run=1 from leaking a FETCH strobe.
    assign writePC        = reset_n & w_write_pc;
    assign writeRA        = reset_n & w_write_ra;
    assign PCsrc          = reset_n & w_pc_src;
    assign ImRPC          = reset_n & w_imr_pc;
    assign restore        = reset_n & w_restore;
    assign Memsrc         = reset_n & w_mem_src;
    assign MemR1          = reset_n & w_mem_r1;
    assign MemR2          = reset_n & w_mem_r2;
    assign MemW1          = 1'b0;
    assign MemW2          = reset_n & w_mem_w2;
    assign conditionalBop = reset_n & w_cond_bop;
    assign regWrite       = reset_n & w_reg_write;
    assign aluSrc         = reset_n & w_alu_src;
    assign memToReg       = reset_n & w_mem_to_reg;
    assign halted         = reset_n & w_halted;
    assign illegal        = reset_n & w_illegal;
    assign instrCount     = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_control_fsm                                                |
// | Purpose  : Scoreboard bench for control_fsm. Stimulus pushes the         |
// |            hand-computed strobe vector and retire count for each cycle;  |
// |            a monitor pops and compares on every falling edge.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_control_fsm;

    // Strobe vector bit map: {writePC,writeRA,PCsrc,ImRPC,restore,Memsrc,
    // MemR1,MemR2,MemW1,MemW2,conditionalBop,regWrite,aluSrc,memToReg,
    // halted,illegal}
    localparam logic [15:0] c_WPC = 16'h8000;
    localparam logic [15:0] c_WRA = 16'h4000;
    localparam logic [15:0] c_PCS = 16'h2000;
    localparam logic [15:0] c_IMR = 16'h1000;
    localparam logic [15:0] c_RST = 16'h0800;
    localparam logic [15:0] c_MSR = 16'h0400;
    localparam logic [15:0] c_MR1 = 16'h0200;
    localparam logic [15:0] c_MR2 = 16'h0100;
    localparam logic [15:0] c_MW2 = 16'h0040;
    localparam logic [15:0] c_CB  = 16'h0020;
    localparam logic [15:0] c_RW  = 16'h0010;
    localparam logic [15:0] c_AS  = 16'h0008;
    localparam logic [15:0] c_M2R = 16'h0004;
    localparam logic [15:0] c_HLT = 16'h0002;
    localparam logic [15:0] c_ILL = 16'h0001;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] IR = 16'h0000;
    logic writePC, writeRA, PCsrc, ImRPC, restore, Memsrc, MemR1, MemR2;
    logic MemW1, MemW2, conditionalBop, regWrite, aluSrc, memToReg;
    logic halted, illegal;
    logic [15:0] instrCount;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk(clk), .reset_n(reset_n), .run(run), .IR(IR),
        .writePC(writePC), .writeRA(writeRA), .PCsrc(PCsrc), .ImRPC(ImRPC),
        .restore(restore), .Memsrc(Memsrc), .MemR1(MemR1), .MemR2(MemR2),
        .MemW1(MemW1), .MemW2(MemW2), .conditionalBop(conditionalBop),
        .regWrite(regWrite), .aluSrc(aluSrc), .memToReg(memToReg),
        .halted(halted), .illegal(illegal), .instrCount(instrCount)
    );

    typedef struct {
        logic [15:0] strb;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t        r_q[$];
    exp_t        r_mon;
    int          r_tests = 0;
    int          r_fails = 0;
    logic [15:0] r_model_cnt = 16'h0000;
    logic [15:0] w_got;

    assign w_got = {writePC, writeRA, PCsrc, ImRPC, restore, Memsrc, MemR1,
                    MemR2, MemW1, MemW2, conditionalBop, regWrite, aluSrc,
                    memToReg, halted, illegal};

    // Monitor: one expected entry per cycle, checked mid-cycle
    always @(negedge clk) begin
        if (r_q.size() != 0) begin
            r_mon = r_q.pop_front();
            r_tests++;
            if (w_got !== r_mon.strb) begin
                r_fails++;
                $display("FAIL %s strobes: got %h required %h", r_mon.name, w_got, r_mon.strb);
            end
            r_tests++;
            if (instrCount !== r_mon.cnt) begin
                r_fails++;
                $display("FAIL %s instrCount: got %h required %h", r_mon.name, instrCount, r_mon.cnt);
            end
        end
    end

    // One clock cycle of stimulus plus its expected response
    task automatic cyc(input logic rn, input logic r, input logic [15:0] ir,
                       input logic [15:0] strb, input logic xinc, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = rn;
        run     = r;
        IR      = ir;
        if (!rn) r_model_cnt = 16'h0000;
        e.strb = strb;
        e.cnt  = r_model_cnt;
        e.name = name;
        r_q.push_back(e);
        if (rn && (strb[15] || xinc)) r_model_cnt = r_model_cnt + 16'h0001;
    endtask

    task automatic go(input logic r, input logic [15:0] ir, input logic [15:0] strb,
                      input string name);
        cyc(1'b1, r, ir, strb, 1'b0, name);
    endtask

    initial begin
        // Reset held with run=1: every output masked
        cyc(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, "reset0");
        cyc(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, "reset1");

        // NOP stream: 5 NOPs in 10 cycles, count reaches 5
        for (int i = 0; i < 5; i++) begin
            go(1'b1, 16'h0000, c_MR1, "nop_fetch");
            go(1'b1, 16'h0000, c_WPC, "nop_decode");
        end

        // CALL
        go(1'b1, 16'h7123, c_MR1, "call_fetch");
        go(1'b1, 16'h7123, 16'h0000, "call_decode");
        go(1'b1, 16'h7123, c_MR2, "call_imm");
        go(1'b1, 16'h7123, c_WPC | c_PCS | c_IMR | c_WRA, "call_exec");

        // LOAD then STORE
        go(1'b1, 16'h3ABC, c_MR1, "load_fetch");
        go(1'b1, 16'h3ABC, 16'h0000, "load_decode");
        go(1'b1, 16'h3ABC, c_MSR | c_MR2, "load_mem");
        go(1'b1, 16'h3ABC, c_RW | c_M2R | c_WPC, "load_wb");
        go(1'b1, 16'h4ABC, c_MR1, "store_fetch");
        go(1'b1, 16'h4ABC, 16'h0000, "store_decode");
        go(1'b1, 16'h4ABC, c_MSR | c_MW2 | c_WPC, "store_mem");

        // ALU imm, BRANCH, JUMP, RET
        go(1'b1, 16'h2001, c_MR1, "alui_fetch");
        go(1'b1, 16'h2001, 16'h0000, "alui_decode");
        go(1'b1, 16'h2001, c_MR2, "alui_imm");
        go(1'b1, 16'h2001, c_RW | c_WPC | c_AS | c_IMR, "alui_wb");
        go(1'b1, 16'h5000, c_MR1, "br_fetch");
        go(1'b1, 16'h5000, 16'h0000, "br_decode");
        go(1'b1, 16'h5000, c_MR2, "br_imm");
        go(1'b1, 16'h5000, c_WPC | c_PCS | c_IMR | c_CB, "br_exec");
        go(1'b1, 16'h6FFF, c_MR1, "jmp_fetch");
        go(1'b1, 16'h6FFF, 16'h0000, "jmp_decode");
        go(1'b1, 16'h6FFF, c_MR2, "jmp_imm");
        go(1'b1, 16'h6FFF, c_WPC | c_PCS | c_IMR, "jmp_exec");
        go(1'b1, 16'h8000, c_MR1, "ret_fetch");
        go(1'b1, 16'h8000, c_RST | c_WPC, "ret_decode");

        // ALU reg with run dropped in WB: retires, then FETCH holds
        go(1'b1, 16'h1234, c_MR1, "alur_fetch");
        go(1'b1, 16'h1234, 16'h0000, "alur_decode");
        go(1'b0, 16'h1234, c_RW | c_WPC, "alur_wb_run0");
        go(1'b0, 16'h1234, 16'h0000, "idle0");
        go(1'b0, 16'h1234, 16'h0000, "idle1");

        // Counter wrap: preload near the top while idling in FETCH
        @(posedge clk);
        #1;
        dut.r_instr_count = 16'hFFFE;
        r_model_cnt = 16'hFFFE;
        for (int i = 0; i < 2; i++) begin
            go(1'b1, 16'h0000, c_MR1, "wrap_fetch");
            go(1'b1, 16'h0000, c_WPC, "wrap_decode");
        end
        go(1'b0, 16'h0000, 16'h0000, "wrap_after");

        // Reset mid-LOAD: abandoned, restart at FETCH
        go(1'b1, 16'h3000, c_MR1, "mid_fetch");
        go(1'b1, 16'h3000, 16'h0000, "mid_decode");
        cyc(1'b0, 1'b1, 16'h3000, 16'h0000, 1'b0, "mid_reset");
        go(1'b1, 16'h0000, c_MR1, "mid_restart");
        go(1'b1, 16'h0000, c_WPC, "mid_nop");

        // Illegal opcode, then HALT for 20 cycles, then reset clears halted
        go(1'b1, 16'hA123, c_MR1, "ill_fetch");
        go(1'b1, 16'hA123, c_WPC | c_ILL, "ill_decode");
        go(1'b1, 16'hF000, c_MR1, "halt_fetch");
        cyc(1'b1, 1'b1, 16'hF000, 16'h0000, 1'b1, "halt_decode");
        for (int i = 0; i < 20; i++) go(1'b1, 16'hF000, c_HLT, "halt_hold");
        cyc(1'b0, 1'b1, 16'hF000, 16'h0000, 1'b0, "halt_reset");
        go(1'b1, 16'h0000, c_MR1, "post_halt");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && r_q.size() != 0; i++) @(negedge clk);
        #1;
        if (r_q.size() != 0) begin
            r_fails++;
            $display("FAIL drain: %0d entries left, required 0", r_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
